// File: rtl/fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// fifo_pkt_reader
//
// Pop-side consumer for the RAM/fall-through FIFOs. Reads length-prefixed
// packets from a FIFO pop interface, strips the header word, and presents
// the payload as a framed valid/ready stream with tlast. A 2-entry output
// buffer absorbs downstream backpressure, so a FIFO word is only popped when
// there is already a place to put it.
//
// Parameters
//   WIDTH      data width, equal to the upstream FIFO width
//   LEN_WIDTH  header length field width (LEN_WIDTH <= WIDTH)
//   CNT_WIDTH  width of the packet and error counters
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   fifo_valid    FIFO head word valid
//   fifo_data     FIFO head word
//   fifo_pop      pop FIFO head (only asserted together with fifo_valid)
//   tvalid        output beat valid
//   tdata         output beat data
//   tlast         last beat of the packet
//   tready        downstream accepts the beat
//   busy          in PAYLOAD state or output buffer non-empty
//   pkt_cnt       packets fully emitted (tlast accepted), wraps
//   err_cnt       zero-length headers dropped, wraps
//   err_zero_len  one-cycle pulse after a zero-length header is consumed
// -----------------------------------------------------------------------------
module fifo_pkt_reader #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_valid,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    output logic                 tvalid,
    output logic [WIDTH-1:0]     tdata,
    output logic                 tlast,
    input  logic                 tready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic                 err_zero_len
);

    typedef enum logic [0:0] {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_r;
    state_t               state_nx_s;
    logic [LEN_WIDTH-1:0] remain_r;
    logic [LEN_WIDTH-1:0] remain_nx_s;
    logic [LEN_WIDTH-1:0] hdr_len_s;

    // Output buffer: entry 0 is always the head, entry 1 the tail when full.
    logic [WIDTH-1:0]     buf_data_r [2];
    logic [1:0]           buf_last_r;
    logic [1:0]           buf_cnt_r;
    logic [1:0]           buf_cnt_nx_s;

    logic                 tvalid_r;
    logic                 busy_r;
    logic [CNT_WIDTH-1:0] pkt_cnt_r;
    logic [CNT_WIDTH-1:0] err_cnt_r;
    logic                 err_zero_len_r;

    logic                 pop_s;
    logic                 push_s;
    logic                 push_last_s;
    logic                 xfer_s;
    logic                 zero_len_s;

    // Header bits above the length field carry no meaning for this block.
    logic                 unused_hdr_bits_s;
    assign unused_hdr_bits_s = ^fifo_data;

    assign hdr_len_s = fifo_data[LEN_WIDTH-1:0];

    // Next-state, pop and buffer-write decisions; only registered state and
    // fifo_valid feed fifo_pop, never tready.
    always_comb begin
        state_nx_s  = state_r;
        remain_nx_s = remain_r;
        pop_s       = 1'b0;
        push_s      = 1'b0;
        push_last_s = 1'b0;
        zero_len_s  = 1'b0;
        if (rst) begin
            pop_s = 1'b0;
        end else begin
            case (state_r)
                ST_HDR: begin
                    pop_s = fifo_valid;
                    if (fifo_valid) begin
                        if (hdr_len_s == LEN_ZERO) begin
                            zero_len_s = 1'b1;
                        end else begin
                            remain_nx_s = hdr_len_s;
                            state_nx_s  = ST_PAYLOAD;
                        end
                    end else begin
                        state_nx_s = ST_HDR;
                    end
                end
                ST_PAYLOAD: begin
                    pop_s = fifo_valid && (buf_cnt_r < 2'd2);
                    if (pop_s) begin
                        push_s      = 1'b1;
                        push_last_s = (remain_r == LEN_ONE);
                        remain_nx_s = remain_r - LEN_ONE;
                        if (remain_r == LEN_ONE) begin
                            state_nx_s = ST_HDR;
                        end else begin
                            state_nx_s = ST_PAYLOAD;
                        end
                    end else begin
                        state_nx_s = ST_PAYLOAD;
                    end
                end
                default: begin
                    state_nx_s  = ST_HDR;
                    remain_nx_s = LEN_ZERO;
                end
            endcase
        end
    end

    // Beat transfer and resulting buffer occupancy.
    always_comb begin
        xfer_s       = tvalid_r && tready;
        buf_cnt_nx_s = buf_cnt_r;
        case ({push_s, xfer_s})
            2'b10:   buf_cnt_nx_s = buf_cnt_r + 2'd1;
            2'b01:   buf_cnt_nx_s = buf_cnt_r - 2'd1;
            default: buf_cnt_nx_s = buf_cnt_r;
        endcase
    end

    assign fifo_pop = pop_s;

    // FSM state and remaining payload length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_HDR;
            remain_r <= LEN_ZERO;
        end else begin
            state_r  <= state_nx_s;
            remain_r <= remain_nx_s;
        end
    end

    // Output buffer storage; a simultaneous write and transfer keeps order.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_r[0] <= {WIDTH{1'b0}};
            buf_data_r[1] <= {WIDTH{1'b0}};
            buf_last_r    <= 2'b00;
            buf_cnt_r     <= 2'd0;
        end else begin
            buf_cnt_r <= buf_cnt_nx_s;
            case ({push_s, xfer_s})
                2'b10: begin
                    if (buf_cnt_r == 2'd0) begin
                        buf_data_r[0] <= fifo_data;
                        buf_last_r[0] <= push_last_s;
                    end else begin
                        buf_data_r[1] <= fifo_data;
                        buf_last_r[1] <= push_last_s;
                    end
                end
                2'b01: begin
                    buf_data_r[0] <= buf_data_r[1];
                    buf_last_r[0] <= buf_last_r[1];
                end
                2'b11: begin
                    if (buf_cnt_r == 2'd1) begin
                        buf_data_r[0] <= fifo_data;
                        buf_last_r[0] <= push_last_s;
                    end else begin
                        buf_data_r[0] <= buf_data_r[1];
                        buf_last_r[0] <= buf_last_r[1];
                        buf_data_r[1] <= fifo_data;
                        buf_last_r[1] <= push_last_s;
                    end
                end
                default: begin
                    buf_last_r <= buf_last_r;
                end
            endcase
        end
    end

    // Registered status flags, computed from next-cycle state so they line
    // up exactly with the buffer and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_r       <= 1'b0;
            busy_r         <= 1'b0;
            err_zero_len_r <= 1'b0;
        end else begin
            tvalid_r       <= (buf_cnt_nx_s != 2'd0);
            busy_r         <= (state_nx_s == ST_PAYLOAD) || (buf_cnt_nx_s != 2'd0);
            err_zero_len_r <= zero_len_s;
        end
    end

    // Wrapping packet and error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_r <= {CNT_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (xfer_s && buf_last_r[0]) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (zero_len_s) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign tvalid       = tvalid_r;
    assign tdata        = buf_data_r[0];
    assign tlast        = buf_last_r[0];
    assign busy         = busy_r;
    assign pkt_cnt      = pkt_cnt_r;
    assign err_cnt      = err_cnt_r;
    assign err_zero_len = err_zero_len_r;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pkt_reader
//
// Scoreboard bench for fifo_pkt_reader. A queue models the upstream FIFO;
// every payload word pushed into it also pushes its expected {tlast, tdata}
// into a scoreboard queue, and an independent monitor pops and compares on
// each accepted beat. Inputs change 1 ns after posedge, outputs are sampled
// on negedge.
// -----------------------------------------------------------------------------
module tb_fifo_pkt_reader;

    localparam int W  = 32;
    localparam int LW = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_valid = 1'b0;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_pop;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic          tlast;
    logic          tready = 1'b0;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_zero_len;

    fifo_pkt_reader #(.WIDTH(W), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_valid   (fifo_valid),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .tvalid       (tvalid),
        .tdata        (tdata),
        .tlast        (tlast),
        .tready       (tready),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt),
        .err_zero_len (err_zero_len)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] fifo_q [$];
    logic [W:0]   exp_q [$];
    int           beat_cyc [$];
    int           rdy_mode = 0;   // 0: tready high, 1: tready low, 2: random
    int           gap_mode = 0;   // 0: FIFO valid whenever non-empty, 1: random gaps
    int           pop_cnt = 0;
    int           zl_pulses = 0;
    int           beat_cnt = 0;
    int           cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic push_payload(input logic [W-1:0] w, input logic last);
        fifo_q.push_back(w);
        exp_q.push_back({last, w});
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy && !tvalid) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_idle"}, done, 1);
    endtask

    // Upstream FIFO model and tready driver.
    initial begin
        logic pop_seen;
        forever begin
            @(negedge clk);
            pop_seen = fifo_pop;
            if (fifo_pop) chk("pop_needs_valid", fifo_valid, 1);
            @(posedge clk);
            #1;
            cyc++;
            if (pop_seen) begin
                pop_cnt++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            fifo_valid = (fifo_q.size() > 0) && (gap_mode == 0 || $urandom_range(0, 3) != 0);
            fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = 1'b0;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard compare and stall-stability check.
    initial begin
        logic         stall_prev = 1'b0;
        logic [W-1:0] hold_d = '0;
        logic         hold_l = 1'b0;
        logic [W:0]   e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                chk("buf_cnt_max", dut.buf_cnt_r <= 2'd2, 1);
                if (err_zero_len) zl_pulses++;
                if (stall_prev) begin
                    chk("hold_tvalid", tvalid, 1);
                    chk("hold_tdata", tdata, hold_d);
                    chk("hold_tlast", tlast, hold_l);
                end
                if (tvalid && tready) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_tdata", tdata, e[W-1:0]);
                        chk("beat_tlast", tlast, e[W]);
                    end
                    beat_cnt++;
                    beat_cyc.push_back(cyc);
                end
                stall_prev = tvalid && !tready;
                hold_d     = tdata;
                hold_l     = tlast;
            end
        end
    end

    // Directed test sequence.
    initial begin
        int base;
        bit reached;
        int lens [10] = '{15, 0, 7, 1, 2, 0, 3, 12, 4, 1};

        // Reset values, with a header already waiting at the FIFO head.
        rst = 1'b1;
        push_word(32'hABCD_0003);           // len 3, upper bits ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_fifo_valid_seen", fifo_valid, 1);
        chk("rst_fifo_pop", fifo_pop, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_zero_len", err_zero_len, 0);

        // Single packet of three beats with tready held high.
        push_payload(32'hAAAA_0001, 1'b0);
        push_payload(32'hBBBB_0002, 1'b0);
        push_payload(32'hCCCC_0003, 1'b1);
        pop_cnt = 0;
        beat_cyc.delete();
        step();
        rst = 1'b0;
        wait_idle("single", 200);
        chk("single_pops", pop_cnt, 4);
        chk("single_pkt_cnt", pkt_cnt, 1);
        chk("single_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) chk("single_consecutive", beat_cyc[2] - beat_cyc[0], 2);

        // Backpressure: len 5 with tready low for 10 cycles.
        rdy_mode = 1;
        step();
        step();
        pop_cnt = 0;
        push_word(32'h0000_0005);
        for (int i = 0; i < 5; i++) push_payload(32'hD000_0000 + 32'(i), i == 4);
        repeat (10) step();
        chk("stall_pops", pop_cnt, 3);
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, 32'hD000_0000);
        chk("stall_fifo_pop", fifo_pop, 0);
        rdy_mode = 0;
        wait_idle("stall", 200);
        chk("stall_total_pops", pop_cnt, 6);
        chk("stall_pkt_cnt", pkt_cnt, 2);

        // Zero-length header followed by a one-beat packet.
        zl_pulses = 0;
        push_word(32'h5A5A_5A50);           // len 0 despite non-zero upper bits
        push_word(32'h0000_0001);
        push_payload(32'hC0FF_EE00, 1'b1);
        wait_idle("zero", 200);
        chk("zero_pulses", zl_pulses, 1);
        chk("zero_err_cnt", err_cnt, 1);
        chk("zero_pkt_cnt", pkt_cnt, 3);

        // Back-to-back single-beat packets: one header bubble between beats.
        beat_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            push_word(32'h0000_0001);
            push_payload(32'h4000_0000 + 32'(k), 1'b1);
        end
        wait_idle("b2b", 200);
        chk("b2b_beats", beat_cyc.size(), 4);
        if (beat_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("b2b_gap", beat_cyc[k] - beat_cyc[k-1], 2);
        end
        chk("b2b_pkt_cnt", pkt_cnt, 7);

        // Reset after two of four beats are accepted.
        base = beat_cnt;
        reached = 1'b0;
        push_word(32'h0000_0004);
        for (int i = 0; i < 4; i++) push_payload(32'hE000_0000 + 32'(i), i == 3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (beat_cnt >= base + 2) begin
                reached = 1'b1;
                break;
            end
        end
        chk("midrst_two_beats", reached, 1);
        rdy_mode = 1;
        step();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_tdata", tdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        rdy_mode = 0;
        push_word(32'h0000_0002);
        push_payload(32'hF000_0000, 1'b0);
        push_payload(32'hF000_0001, 1'b1);
        wait_idle("midrst", 200);
        chk("midrst_after_pkt_cnt", pkt_cnt, 1);

        // Stress: random tready and FIFO gaps over lengths 0..15.
        zl_pulses = 0;
        rdy_mode  = 2;
        gap_mode  = 1;
        for (int p = 0; p < 10; p++) begin
            push_word(32'hFEDC_BA90 | 32'(lens[p]));
            for (int i = 0; i < lens[p]; i++)
                push_payload(32'h1000_0000 + 32'(p * 256 + i), i == lens[p] - 1);
        end
        wait_idle("stress", 4000);
        rdy_mode = 0;
        gap_mode = 0;
        chk("stress_pkt_cnt", pkt_cnt, 9);
        chk("stress_err_cnt", err_cnt, 2);
        chk("stress_pulses", zl_pulses, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Pop-side consumer for the RAM/fall-through FIFOs. Drains length-prefixed packets from a FIFO pop interface (pop/pop_data/valid) and presents them as a framed valid/ready stream with `tlast`. It strips the header word and provides a 2-entry output buffer so that downstream backpressure never stalls the FIFO mid-word. It sits between a `ram_fifo_ft` instance and any stream consumer (DMA write engine, MMIO response path).

## Interface
- `WIDTH`, 32: data width. Must match the upstream FIFO width.
- `LEN_WIDTH`, 16: header length field width. Constraint: LEN_WIDTH <= WIDTH.
- `CNT_WIDTH`, 32: width of the packet and error counters.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `fifo_valid`  in  1  FIFO head word valid
- `fifo_data`  in  WIDTH  FIFO head word
- `fifo_pop`  out  1  pop FIFO head; only asserted with `fifo_valid`
- `tvalid`  out  1  output beat valid
- `tdata`  out  WIDTH  output beat data
- `tlast`  out  1  last beat of packet
- `tready`  in  1  downstream accepts beat
- `busy`  out  1  in PAYLOAD state or output buffer non-empty
- `pkt_cnt`  out  CNT_WIDTH  packets fully emitted (tlast accepted)
- `err_cnt`  out  CNT_WIDTH  zero-length headers dropped
- `err_zero_len`  out  1  one-cycle pulse when a zero-length header is consumed

## Operation
- FSM states: HDR, PAYLOAD. Reset state is HDR.
- HDR:
  - `fifo_pop = fifo_valid`. The header needs no buffer space.
  - On pop, `len = fifo_data[LEN_WIDTH-1:0]`.
  - If len == 0: stay in HDR, pulse `err_zero_len`, increment `err_cnt`. Nothing is emitted.
  - Otherwise: load `remain = len` and go to PAYLOAD.
- PAYLOAD:
  - `fifo_pop = fifo_valid && (buf_cnt < 2)`. `buf_cnt` is the registered occupancy of the output buffer.
  - Each popped word enters the output buffer with `last = (remain == 1)`, and `remain` decrements.
  - Popping the word with remain == 1 returns the FSM to HDR.
- Output buffer: 2-entry FIFO of {data, last}. Head drives `tdata`/`tlast`; `tvalid = (buf_cnt != 0)`. A beat is transferred when `tvalid && tready`.
- Simultaneous buffer write and transfer: `buf_cnt` is unchanged and ordering is preserved.
- `pkt_cnt` increments on a transfer with `tlast == 1`. It wraps modulo 2^CNT_WIDTH, as does `err_cnt`.
- `tdata`/`tlast`/`tvalid` are held stable while `tvalid && !tready`.
- Unused header bits above LEN_WIDTH are ignored.

## Timing
- Reset values:
  - `tvalid` = 0, `tlast` = 0, `tdata` = 0.
  - `fifo_pop` = 0 while `rst` is high.
  - `busy` = 0, `pkt_cnt` = 0, `err_cnt` = 0, `err_zero_len` = 0.
  - FSM = HDR, `buf_cnt` = 0, `remain` = 0.
- Reset mid-packet: the in-flight packet is abandoned and buffered beats are discarded. The next word after reset is parsed as a header. The upstream FIFO is reset alongside.
- Latency: a payload word popped in cycle N is on `tvalid`/`tdata` in cycle N+1.
- Header pop in cycle N → earliest first payload pop in cycle N+1 → first `tvalid` in cycle N+2.
- Throughput:
  - 1 beat/cycle within a packet when `tready` is held high.
  - One bubble cycle per header between back-to-back packets.
- Backpressure: with `tready` = 0, at most 2 payload words are popped, then `fifo_pop` deasserts. Popping resumes the cycle after `buf_cnt` drops below 2.
- `fifo_pop` is combinational from `fifo_valid` and registered state only. There is no combinational path from `tready` to `fifo_pop`.
- `err_zero_len` is registered: high in cycle N+1 for a zero-length header popped in cycle N.
- `pkt_cnt` updates the cycle after the `tlast` transfer.

## Test plan
- **Single packet:** FIFO holds {hdr len=3, A, B, C}, `tready` = 1 → beats A, B, C on consecutive cycles, `tlast` only on C, `pkt_cnt` = 1, `fifo_pop` asserted 4 times.
- **Backpressure:** len=5, `tready` = 0 for 10 cycles, then 1 → exactly 2 payload pops during the stall, `tdata` stable, all 5 beats delivered in order, `tlast` on beat 5.
- **Zero length:** {hdr len=0, hdr len=1, X} → `err_zero_len` pulses once, `err_cnt` = 1, single beat X with `tlast`, `pkt_cnt` = 1.
- **Back-to-back:** 4 packets of len=1 with the FIFO continuously valid and `tready` = 1 → 4 beats, all `tlast`, one bubble between each, `pkt_cnt` = 4.
- **Reset mid-packet:** len=4 with 2 beats accepted, then `rst` for 1 cycle → `tvalid` = 0 the cycle after reset, counters 0, next word is treated as a header.
- **Random stress:** random `tready` and `fifo_valid` gaps, lengths 0..2^LEN_WIDTH-1 (test with LEN_WIDTH=4) → a scoreboard matches every payload word and `tlast` position, `fifo_pop` never asserts without `fifo_valid`, `buf_cnt` never exceeds 2.
